// File: rtl/shift_sub_divider.sv
// shift_sub_divider: unsigned 8-bit / 8-bit restoring divider.
// A SHIFT/SUB pair is run once per quotient bit. The whole divide therefore
// takes 16 busy cycles. The result is then held in HOLD until run drops.
module shift_sub_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic       run,
  input  logic [7:0] sw,
  output logic [7:0] Qval,
  output logic [7:0] Aval,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SUB   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [7:0] q_q,     q_d;
  logic [8:0] a_q,     a_d;
  logic [7:0] d_q,     d_d;
  logic       dbz_q,   dbz_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic [8:0] sub_t;

  // Trial subtraction of the divisor from the partial remainder.
  assign sub_t = a_q - {1'b0, d_q};

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    a_d     = a_q;
    d_d     = d_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          // run wins over ld; the divisor is captured only on this edge
          d_d   = sw;
          cnt_d = 3'd0;
          if (sw == 8'd0) begin
            // divide by zero: skip the iterations, A keeps its prior value
            dbz_d   = 1'b1;
            q_d     = 8'hFF;
            state_d = S_HOLD;
          end else begin
            dbz_d   = 1'b0;
            a_d     = 9'd0;
            state_d = S_SHIFT;
          end
        end else if (ld) begin
          q_d   = sw;
          a_d   = 9'd0;
          dbz_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // A[8] is always 0 here because A < D after every SUB step.
        a_d     = {a_q[7:0], q_q[7]};
        q_d     = {q_q[6:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        if (a_q >= {1'b0, d_q}) begin
          a_d    = sub_t;
          q_d[0] = 1'b1;
        end else begin
          a_d = a_q;
        end
        if (cnt_q == 3'd7) begin
          state_d = S_HOLD;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_SHIFT;
        end
      end
      S_HOLD: begin
        // One divide per run press: leave only after run is released.
        if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are computed from the next state and registered, so no input reaches them combinationally.
  always_comb begin
    busy_d = (state_d == S_SHIFT) || (state_d == S_SUB);
    done_d = (state_d == S_HOLD);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      a_q     <= 9'd0;
      d_q     <= 8'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      a_q     <= a_d;
      d_q     <= d_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Qval = q_q;
  assign Aval = a_q[7:0];
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule
